// File: rtl/booth_mult_if.sv
// Handshake/operand bundle between the Booth multiplier and its requester / Booth CU.
interface booth_mult_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [1:0]           booth_op;
  logic                 lsb;
  logic                 L;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier, booth_op,
    input  lsb, L, busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, booth_op,
    output lsb, L, busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one add/sub + arithmetic shift per clock.
// Optional BOOTH_INTERNAL_DECODE_EN decodes the op from {Q[0], L} and ignores booth_op.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  booth_mult_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 l_q, l_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [1:0]           op;
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       a_sum;

`ifdef BOOTH_INTERNAL_DECODE_EN
  logic unused_booth_op;
  assign op              = {q_q[0], l_q};
  assign unused_booth_op = ^bus.booth_op;
`else
  assign op = bus.booth_op;
`endif

  // A is one bit wider than M so that subtracting the most negative M cannot overflow.
  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    a_sum = a_q;
    case (op)
      2'b01:   a_sum = a_q + m_ext;
      2'b10:   a_sum = a_q - m_ext;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    l_d       = l_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          l_d     = 1'b0;
          m_d     = bus.multiplicand;
          count_d = CW'(WIDTH);
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d     = {a_sum[0], q_q[WIDTH-1:1]};
        l_d     = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      l_q       <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      l_q       <= l_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign bus.lsb     = q_q[0];
  assign bus.L       = l_q;
  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: directed WIDTH=8 scenarios plus randomized WIDTH=16/32 runs
// checked against a plain signed-multiply reference.
module tb_booth_mult_seq;
  logic clk;
  logic rst_n;
  logic force11;
  int   passed;
  int   total;

  booth_mult_if #(.WIDTH(8))  if8 ();
  booth_mult_if #(.WIDTH(16)) if16 ();
  booth_mult_if #(.WIDTH(32)) if32 ();

  booth_mult_seq #(.WIDTH(8))  d8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  booth_mult_seq #(.WIDTH(16)) d16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  booth_mult_seq #(.WIDTH(32)) d32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  // Bench-side Booth CU: {Q0, L} = 10 subtract, 01 add, else no-op.
  assign if8.booth_op  = force11 ? 2'b11 : {if8.lsb, if8.L};
  assign if16.booth_op = {if16.lsb, if16.L};
  assign if32.booth_op = {if32.lsb, if32.L};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Full-timing run on the 8-bit unit: busy in cycles 1..8, done in cycle 9.
  task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp,
                      input string tag);
    @(negedge clk);
    if8.start = 1'b1; if8.multiplicand = m; if8.multiplier = q;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if8.start = 1'b0;
      chk({tag, "_busy"}, 64'(if8.busy), 64'(c <= 8));
      chk({tag, "_done"}, 64'(if8.done), 64'(c == 9));
    end
    chk({tag, "_prod"}, 64'(if8.product), 64'(exp));
  endtask

  task automatic run16(input logic [15:0] m, input logic [15:0] q);
    longint e;
    int     c;
    e = longint'($signed(m)) * longint'($signed(q));
    @(negedge clk);
    if16.start = 1'b1; if16.multiplicand = m; if16.multiplier = q;
    @(negedge clk);
    if16.start = 1'b0;
    c = 1;
    while (!if16.done && c < 22) begin
      @(negedge clk);
      c++;
    end
    chk("lat16", 64'(c), 64'd17);
    chk("prod16", 64'(if16.product), 64'(e[31:0]));
  endtask

  task automatic run32(input logic [31:0] m, input logic [31:0] q);
    longint e;
    int     c;
    e = longint'($signed(m)) * longint'($signed(q));
    @(negedge clk);
    if32.start = 1'b1; if32.multiplicand = m; if32.multiplier = q;
    @(negedge clk);
    if32.start = 1'b0;
    c = 1;
    while (!if32.done && c < 38) begin
      @(negedge clk);
      c++;
    end
    chk("lat32", 64'(c), 64'd33);
    chk("prod32", 64'(if32.product), 64'(e));
  endtask

  initial begin
    int ndone;
    passed  = 0;
    total   = 0;
    force11 = 1'b0;
    rst_n   = 1'b0;
    if8.start  = 1'b0; if8.multiplicand  = '0; if8.multiplier  = '0;
    if16.start = 1'b0; if16.multiplicand = '0; if16.multiplier = '0;
    if32.start = 1'b0; if32.multiplicand = '0; if32.multiplier = '0;

    #12;
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_prod", 64'(if8.product), 64'd0);
    chk("rst_lsb", 64'(if8.lsb), 64'd0);
    chk("rst_L", 64'(if8.L), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'd3, 8'hFB, 16'hFFF1, "m3xn5");
    run8(8'h80, 8'h80, 16'h4000, "minxmin");
    run8(8'h7F, 8'h80, 16'hC080, "maxxmin");

    // Starts during RUN are ignored; a start in the DONE cycle launches the next run.
    @(negedge clk);
    if8.start = 1'b1; if8.multiplicand = 8'd3; if8.multiplier = 8'hFB;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if8.start = 1'b0;
      chk("ign_busy", 64'(if8.busy), 64'(c <= 8));
      chk("ign_done", 64'(if8.done), 64'(c == 9));
      if (c == 3 || c == 5) begin
        if8.start = 1'b1; if8.multiplicand = 8'd1; if8.multiplier = 8'd1;
      end
      if (c == 9) begin
        chk("ign_prod", 64'(if8.product), 64'h0000_0000_0000_FFF1);
        if8.start = 1'b1; if8.multiplicand = 8'd0; if8.multiplier = 8'd99;
      end
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if8.start = 1'b0;
      chk("b2b_busy", 64'(if8.busy), 64'(c <= 8));
      chk("b2b_done", 64'(if8.done), 64'(c == 9));
      if (c == 1) chk("b2b_hold", 64'(if8.product), 64'h0000_0000_0000_FFF1);
    end
    chk("b2b_prod", 64'(if8.product), 64'd0);
    @(negedge clk);
    chk("b2b_idle", 64'(if8.done), 64'd0);

    // Abort mid-RUN with reset.
    run8(8'd3, 8'hFB, 16'hFFF1, "pre_rst");
    @(negedge clk);
    if8.start = 1'b1; if8.multiplicand = 8'd3; if8.multiplier = 8'hFB;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(if8.busy), 64'd0);
    chk("abort_done", 64'(if8.done), 64'd0);
    chk("abort_prod", 64'(if8.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    chk("abort_nodone", 64'(ndone), 64'd0);
    run8(8'd7, 8'd6, 16'h002A, "m7x6");

    force11 = 1'b1;
`ifdef BOOTH_INTERNAL_DECODE_EN
    run8(8'd5, 8'd9, 16'h002D, "op11");
`else
    run8(8'd5, 8'd9, 16'h0000, "op11");
`endif
    force11 = 1'b0;

    run16(16'h8000, 16'h8000);
    run16(16'h7FFF, 16'h8000);
    run32(32'h8000_0000, 32'h8000_0000);
    run32(32'h7FFF_FFFF, 32'h8000_0000);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] r0;
      logic [31:0] r1;
      r0 = $urandom;
      r1 = $urandom;
      run16(r0[15:0], r1[15:0]);
    end
    for (int i = 0; i < 1000; i++) run32($urandom, $urandom);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
